// File: rtl/man_serializer_pkg.sv
// Shared constants and the byte-to-symbol encoder for man_serializer.
// Build option: MAN_SERIALIZER_MANCHESTER_EN selects Manchester (16 symbols
// per byte); without it each byte goes out as raw NRZ (8 symbols per byte).
package man_serializer_pkg;

    localparam int DATA_W = 8;
`ifdef MAN_SERIALIZER_MANCHESTER_EN
    localparam int SYM_W  = 16;
`else
    localparam int SYM_W  = 8;
`endif
    localparam int REM_W  = 5;

    // Symbol i of the result is transmitted i-th, so bit 0 goes out first.
    function automatic logic [SYM_W-1:0] man_encode(input logic [DATA_W-1:0] d);
        logic [SYM_W-1:0] enc;
        enc = '0;
`ifdef MAN_SERIALIZER_MANCHESTER_EN
        // Data 1 becomes "1 then 0", data 0 becomes "0 then 1".
        for (int i = 0; i < DATA_W; i++) begin
            enc[2*i]   = d[i];
            enc[2*i+1] = ~d[i];
        end
`else
        enc = d;
`endif
        return enc;
    endfunction

endpackage

// File: rtl/man_encode_comb.sv
// Purely combinational wrapper around the package encoder.
// Build option: MAN_SERIALIZER_MANCHESTER_EN (see man_serializer_pkg).
module man_encode_comb
    import man_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [SYM_W-1:0]  enc
);

    // Encode the byte currently offered on the input port.
    always_comb begin
        enc = man_encode(data);
    end

endmodule

// File: rtl/man_serializer.sv
// Bit-serial line transmitter: accepts bytes over valid/ready and shifts the
// encoded symbols out one per clock, LSB first, from a registered output.
// Build option: MAN_SERIALIZER_MANCHESTER_EN selects Manchester encoding
// (16 symbols per byte); undefined gives raw NRZ (8 symbols per byte).
//
// Handshake: a byte is transferred on a rising edge where s_valid and s_ready
// are both high. s_ready rises while at most the final symbol of the previous
// byte is still pending, so a held s_valid yields a gap-free stream. s_data is
// only sampled on the transfer edge.
module man_serializer
    import man_serializer_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              underrun
);

    localparam int SR_W = SYM_W - 1;

    logic [SR_W-1:0]  sr;
    logic [REM_W-1:0] rem;
    logic [SYM_W-1:0] enc;
    logic             accept;

    man_encode_comb u_encode (
        .data (s_data),
        .enc  (enc)
    );

    // Ready while the line holds at most its last pending symbol.
    always_comb begin
        s_ready = sys_rst_n && (rem <= REM_W'(1));
        accept  = s_valid && s_ready;
        busy    = (rem != '0);
    end

    // Load a new byte, shift out pending symbols, or drop back to idle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            serial_out <= IDLE_LEVEL;
            sr         <= '0;
            rem        <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                serial_out <= enc[0];
                sr         <= enc[SYM_W-1:1];
                rem        <= REM_W'(SYM_W);
            end else if (rem > REM_W'(1)) begin
                serial_out <= sr[0];
                sr         <= {1'b0, sr[SR_W-1:1]};
                rem        <= rem - REM_W'(1);
            end else if (rem == REM_W'(1)) begin
                serial_out <= IDLE_LEVEL;
                rem        <= '0;
                underrun   <= 1'b1;
            end else begin
                serial_out <= IDLE_LEVEL;
            end
        end
    end

endmodule

// File: tb/tb_man_serializer.sv
// Directed and randomized bench for man_serializer. The reference keeps the
// symbols still owed to the line (current one first) in a queue.
module tb_man_serializer;

    localparam logic IDLE = 1'b0;
`ifdef MAN_SERIALIZER_MANCHESTER_EN
    localparam int TB_SYM = 16;
`else
    localparam int TB_SYM = 8;
`endif

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       serial_out;
    logic       busy;
    logic       underrun;

    int checks;
    int errors;

    logic line_q[$];
    logic acc;
    logic und;

    man_serializer #(.IDLE_LEVEL(IDLE)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .underrun   (underrun)
    );

    // Clock: 10 ns period.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Symbols of one byte in transmit order.
    task automatic push_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            line_q.push_back(d[i]);
`ifdef MAN_SERIALIZER_MANCHESTER_EN
            line_q.push_back(~d[i]);
`endif
        end
    endtask

    task automatic check_outputs();
        chk("serial_out", {31'd0, serial_out}, {31'd0, (line_q.size() != 0) ? line_q[0] : IDLE});
        chk("busy",       {31'd0, busy},       {31'd0, line_q.size() != 0});
        chk("s_ready",    {31'd0, s_ready},    {31'd0, sys_rst_n && (line_q.size() <= 1)});
        chk("underrun",   {31'd0, underrun},   {31'd0, und});
    endtask

    // One clock: advance the reference at the edge, compare at the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        acc = 1'b0;
        und = 1'b0;
        if (!sys_rst_n) begin
            line_q.delete();
        end else if (s_valid && line_q.size() <= 1) begin
            acc = 1'b1;
            line_q.delete();
            push_byte(s_data);
        end else if (line_q.size() != 0) begin
            void'(line_q.pop_front());
            if (line_q.size() == 0) und = 1'b1;
        end
        @(negedge sys_clk);
        check_outputs();
    endtask

    initial begin
        logic [15:0] want;
        logic [15:0] got;
        int          n_und;
        int          n_acc;

        checks    = 0;
        errors    = 0;
        acc       = 1'b0;
        und       = 1'b0;
        sys_rst_n = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;

        // Reset and idle.
        #1;
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_out",   {31'd0, serial_out}, {31'd0, IDLE});
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        repeat (3) tick();

        // Single byte 0xA5 against the literal expected symbol stream.
`ifdef MAN_SERIALIZER_MANCHESTER_EN
        want = 16'b0110_0110_1001_1001;
`else
        want = 16'h00A5;
`endif
        got     = '0;
        s_data  = 8'hA5;
        s_valid = 1'b1;
        tick();
        chk("a5_accept", {31'd0, acc}, 32'd1);
        s_valid = 1'b0;
        got[0]  = serial_out;
        for (int k = 1; k < TB_SYM; k++) begin
            s_data = 8'($urandom);
            tick();
            got[k] = serial_out;
        end
        chk("a5_stream", {16'd0, got}, {16'd0, want});
        tick();
        chk("a5_underrun", {31'd0, underrun}, 32'd1);
        repeat (2) tick();

        // Back-to-back 0x00 then 0xFF with s_valid held.
        n_und   = 0;
        n_acc   = 0;
        s_data  = 8'h00;
        s_valid = 1'b1;
        tick();
        chk("b2b_first_accept", {31'd0, acc}, 32'd1);
        n_acc   = 1;
        s_data  = 8'hFF;
        for (int k = 1; k < 2 * TB_SYM; k++) begin
            tick();
            if (acc) begin
                n_acc++;
                s_valid = 1'b0;
                chk("b2b_second_at", k, TB_SYM);
            end
            if (underrun) n_und++;
        end
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_no_underrun", n_und, 0);
        repeat (3) tick();

        // Reset in the middle of 0xA5.
        s_data  = 8'hA5;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (5) tick();
        sys_rst_n = 1'b0;
        line_q.delete();
        und = 1'b0;
        #1;
        chk("abort_out",   {31'd0, serial_out}, {31'd0, IDLE});
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, s_ready}, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        repeat (TB_SYM + 2) tick();

        // Randomized traffic with s_data churn while busy.
        for (int k = 0; k < 600; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (TB_SYM + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/man_serializer.md
# man_serializer

Bit-serial line transmitter for the board's single-ended or LVDS test output. It accepts bytes over a valid/ready handshake and Manchester-encodes each byte into 16 half-bit symbols. It shifts the symbols out one per clock, LSB first, from a registered output. It replaces the vendor 8:1 serializer, the clock-enable buffer and the PLL-derived parallel clock with one soft block on a single clock domain.

## Interface
- `IDLE_LEVEL`, default 1'b0: level driven on `serial_out` when no symbols are pending.
- `sys_clk`  in  1  symbol clock; one output symbol per rising edge.
- `sys_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `s_data`  in  8  byte to transmit.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block accepts a byte on this edge.
- `serial_out`  out  1  registered serial symbol stream.
- `busy`  out  1  symbols still pending, including the one currently on `serial_out`.
- `underrun`  out  1  one-cycle pulse when the stream runs dry after the last symbol.

## Operation
- Internal state:
  - `sr`: 15-bit shift register of symbols not yet driven.
  - `rem`: 5-bit count of symbols pending, including the one on `serial_out`; range 0..16.
- Encoding, data bit i maps to symbol pair (2i, 2i+1) = (d[i], ~d[i]):
  - data 1 is sent as "1 then 0"; data 0 is sent as "0 then 1".
  - Symbol 0 goes out first, so data is sent LSB first.
- `s_ready` = `sys_rst_n` AND (`rem` <= 1). Accept happens when `s_valid` and `s_ready` are both high at a rising edge.
- On accept: `serial_out` <= enc[0], `sr` <= enc[15:1], `rem` <= 16.
- Else if `rem` > 1: `serial_out` <= `sr[0]`, `sr` shifts right, `rem` decrements.
- Else if `rem` == 1: `serial_out` <= `IDLE_LEVEL`, `rem` <= 0, `underrun` pulses for one cycle.
- Else (idle): hold `IDLE_LEVEL`.
- `busy` = (`rem` != 0).
- `s_data` is sampled only on the accept edge. Changes to `s_data` at any other time have no effect.

## Timing
- Reset values: `serial_out` = `IDLE_LEVEL`, `rem` = 0, `sr` = 0, `underrun` = 0, `busy` = 0.
- `s_ready` is 0 while reset is asserted and 1 after release.
- Latency: the first symbol appears on `serial_out` in the cycle after the accept edge.
- Byte period is 16 cycles (8 cycles with the macro undefined).
- Back-to-back transfers: a byte presented with `s_valid` held high is accepted on the edge where the last symbol of the previous byte is replaced, so the stream has no gap.
  - `underrun` does not pulse in this case.
- Stall: if `s_valid` is low when `rem` == 1, the line returns to `IDLE_LEVEL` for at least one cycle.
- A reset asserted mid-byte aborts the byte immediately. No partial symbols are emitted after reset release.

## Configuration
- `MAN_SERIALIZER_MANCHESTER_EN` defined: Manchester encoding as above, 16 symbols per byte, `rem` loads 16.
- Macro undefined: raw NRZ, 8 symbols per byte, enc = `s_data`, `rem` loads 8, LSB first. Handshake, `underrun` and `IDLE_LEVEL` behaviour are unchanged.

## Structure
- Package `man_serializer_pkg`:
  - `DATA_W` = 8.
  - `SYM_W` = 16 or 8 per the macro.
  - `REM_W` = 5.
  - function `man_encode(byte) -> SYM_W` bits.
- One sub-module `man_encode_comb`: purely combinational encoder wrapping the package function. Everything else lives in the top.

## Test plan
- Reset then idle with `IDLE_LEVEL` = 0 → `serial_out` = 0, `busy` = 0, `s_ready` = 1; during reset `s_ready` = 0.
- Send single byte 0xA5 with macro defined → `serial_out` = 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0 starting the cycle after accept. Then `underrun` pulses once and the line is idle.
- Back-to-back 0x00 then 0xFF with `s_valid` held → 0,1 ×8 then 1,0 ×8. 32 contiguous cycles, no `underrun` between bytes, `s_ready` high only on the accept cycles.
- Macro undefined, send 0xA5 → 1,0,1,0,0,1,0,1 over 8 cycles, then idle.
- Assert `sys_rst_n` low at symbol 5 of 0xA5 → `serial_out` = `IDLE_LEVEL` immediately, `busy` = 0; after release no leftover symbols appear.
- `s_valid` high while `rem` > 1 → no accept, and `s_data` changes do not corrupt the byte in flight.
